// File: rtl/cnu_msg_gen_pkg.sv
// Shared check-node definitions: default widths, message width, sign-magnitude packing, offset saturation.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Helpers work on a fixed 32-bit magnitude container so one function serves every instantiated width;
// callers zero-extend into mag_t and size-cast the result back down.
package cnu_msg_gen_pkg;

    localparam int unsigned CNU_DATA_W = 8;
    localparam int unsigned CNU_IDX_W  = 8;
    localparam int unsigned CNU_D      = 5;
    localparam int unsigned CNU_LAT    = 2;
    localparam int unsigned CNU_OFFSET = 1;
    localparam int unsigned MAG_MAX_W  = 32;

    typedef logic [MAG_MAX_W-1:0] mag_t;
    typedef logic [MAG_MAX_W:0]   sm_t;

    // A message is one sign bit above a data_w-bit magnitude.
    function automatic int unsigned msg_width(input int unsigned data_w);
        return data_w + 1;
    endfunction

    // Offset min-sum magnitude correction; clamps at zero instead of wrapping.
    function automatic mag_t offset_sat(input mag_t mag, input mag_t offset);
        return (mag > offset) ? (mag - offset) : '0;
    endfunction

    // Places the sign at bit w above a magnitude that must already fit in w bits.
    function automatic sm_t sm_pack(input logic sign, input mag_t mag, input int unsigned w);
        return {1'b0, mag} | ({{MAG_MAX_W{1'b0}}, sign} << w);
    endfunction

    function automatic logic sm_sign(input sm_t msg, input int unsigned w);
        sm_t tmp;
        tmp = msg >> w;
        return tmp[0];
    endfunction

    function automatic mag_t sm_mag(input sm_t msg, input int unsigned w);
        sm_t mask;
        mask = ({{MAG_MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
        return mag_t'(msg & mask);
    endfunction

endpackage

// File: rtl/cnu_msg_gen_if.sv
// Row-level bus between the merge tree / sign source and the check-to-variable message generator.
// Latency: n/a (wires only).
// Backpressure: none; master presents rows and results, slave produces messages every cycle.
// Ports: in_valid/in_sign (row entry), min/min2/min_idx (merge-tree results LAT cycles later),
//        out_msg/out_valid (generated messages).
interface cnu_msg_gen_if #(
    parameter int unsigned data_w = 8,
    parameter int unsigned idx_w  = 8,
    parameter int unsigned D      = 5
) ();
    logic                      in_valid;
    logic [D-1:0]              in_sign;
    logic [data_w-1:0]         min;
    logic [data_w-1:0]         min2;
    logic [idx_w-1:0]          min_idx;
    logic [(data_w+1)*D-1:0]   out_msg;
    logic                      out_valid;

    modport master (
        output in_valid, in_sign, min, min2, min_idx,
        input  out_msg, out_valid
    );

    modport slave (
        input  in_valid, in_sign, min, min2, min_idx,
        output out_msg, out_valid
    );
endinterface

// File: rtl/cnu_sign_dly.sv
// Valid+data delay line keeping row signs aligned with the merge-tree pipeline.
// Latency: LAT cycles (LAT=0 is a straight wire).
// Backpressure: none; shifts every cycle, synchronous rst clears valid and data.
// Ports: clk, rst, in_vld/in_dat (row entry), out_vld/out_dat (delayed copy).
module cnu_sign_dly #(
    parameter int unsigned W   = 5,
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);
    if (LAT == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_vld = in_vld;
        assign out_dat = in_dat;
    end else begin : g_regs
        logic         vld_sr [LAT];
        logic [W-1:0] dat_sr [LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < LAT; i++) begin
                    vld_sr[i] <= 1'b0;
                    dat_sr[i] <= '0;
                end
            end else begin
                vld_sr[0] <= in_vld;
                dat_sr[0] <= in_dat;
                for (int i = 1; i < LAT; i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                    dat_sr[i] <= dat_sr[i-1];
                end
            end
        end

        assign out_vld = vld_sr[LAT-1];
        assign out_dat = dat_sr[LAT-1];
    end
endmodule

// File: rtl/cnu_msg_gen.sv
// Check-node output stage: offset min-sum check-to-variable messages, sign-magnitude, D lanes per row.
// Latency: LAT+2 cycles from in_valid to out_valid; one row per cycle, no bubbles.
// Backpressure: none; synchronous rst drops every in-flight row.
// Ports: clk, rst, bus (slave: in_valid/in_sign/min/min2/min_idx in, out_msg/out_valid out).
module cnu_msg_gen
    import cnu_msg_gen_pkg::*;
#(
    parameter int unsigned data_w = CNU_DATA_W,
    parameter int unsigned idx_w  = CNU_IDX_W,
    parameter int unsigned D      = CNU_D,
    parameter int unsigned LAT    = CNU_LAT,
    parameter int unsigned OFFSET = CNU_OFFSET
) (
    input  logic          clk,
    input  logic          rst,
    cnu_msg_gen_if.slave  bus
);
    localparam int unsigned MSG_W = msg_width(data_w);

    // Stage 0: signs delayed to line up with min/min2/min_idx.
    logic         dv;
    logic [D-1:0] ds;

    cnu_sign_dly #(
        .W   (D),
        .LAT (LAT)
    ) u_sign_dly (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (bus.in_valid),
        .in_dat  (bus.in_sign),
        .out_vld (dv),
        .out_dat (ds)
    );

    // Stage 1: offset-corrected magnitudes and total sign parity.
    logic              v1;
    logic              tot1;
    logic [D-1:0]      s1;
    logic [data_w-1:0] m1;
    logic [data_w-1:0] m2_1;
    logic [idx_w-1:0]  i1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            tot1 <= 1'b0;
            s1   <= '0;
            m1   <= '0;
            m2_1 <= '0;
            i1   <= '0;
        end else begin
            v1   <= dv;
            tot1 <= ^ds;
            s1   <= ds;
            m1   <= data_w'(offset_sat(mag_t'(bus.min),  mag_t'(OFFSET)));
            m2_1 <= data_w'(offset_sat(mag_t'(bus.min2), mag_t'(OFFSET)));
            i1   <= bus.min_idx;
        end
    end

    // Stage 2: per-lane extrinsic selection. The min lane gets min2; an index >= D
    // (padding lane from the merge tree) matches no lane, so every lane gets min.
    // The lane's own sign is removed from the total parity; zero magnitudes stay positive.
    logic [D*MSG_W-1:0] next_msg;
    logic [data_w-1:0]  lane_mag;
    logic               lane_neg;

    always_comb begin
        next_msg = '0;
        lane_mag = '0;
        lane_neg = 1'b0;
        for (int k = 0; k < int'(D); k++) begin
            lane_mag = (int'(i1) == k) ? m2_1 : m1;
            lane_neg = (tot1 ^ s1[k]) & (lane_mag != '0);
            next_msg[MSG_W*k +: MSG_W] = MSG_W'(sm_pack(lane_neg, mag_t'(lane_mag), data_w));
        end
    end

    logic [D*MSG_W-1:0] out_msg_q;
    logic               out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_msg_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_msg_q   <= next_msg;
            out_valid_q <= v1;
        end
    end

    assign bus.out_msg   = out_msg_q;
    assign bus.out_valid = out_valid_q;
endmodule
